// File: rtl/bcd_scan_mux_pkg.sv
// Shared types and helpers for the multiplexed BCD display scanner.
package bcd_disp_pkg;

  localparam int BCD_W = 4;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] nibble);
    return nibble <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_scan_mux_if.sv
// Double-buffered load port of the display scanner.
interface bcd_scan_mux_if
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                        load_valid;
  logic                        load_ready;
  logic [BCD_W*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/bcd_scan_timer.sv
// Prescaler and slot index; strobes describe the cycle that follows the next rising edge.
module bcd_scan_timer #(
  parameter int  NUM_DIGITS   = 4,
  parameter int  PRESCALE     = 1000,
  parameter int  BLANK_CYCLES = 8,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             slot_start,
  output logic             show_start,
  output logic             frame_last
);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx;

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    if (cnt == CNT_W'(PRESCALE - 1)) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign slot_start = (cnt_nxt == '0);
  assign show_start = (cnt_nxt == CNT_W'(BLANK_CYCLES));
  assign frame_last = (cnt_nxt == CNT_W'(PRESCALE - 1)) && (idx_nxt == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/bcd_scan_mux.sv
// Scans packed BCD digits onto one bus with dead time, blanking and tear-free buffered updates.
module bcd_scan_mux
  import bcd_disp_pkg::*;
#(
  parameter int  NUM_DIGITS   = 4,
  parameter int  PRESCALE     = 1000,
  parameter int  BLANK_CYCLES = 8,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int DW           = BCD_W * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_scan_mux_if.slave         ld,
  input  logic                  lz_blank_en,
  output logic [BCD_W-1:0]      bcd_out,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  err_invalid,
  output logic                  frame_done,
  output scan_state_t           state_dbg
);

  logic [IDX_W-1:0]      idx_nxt;
  logic                  slot_start, show_start, frame_last;
  logic [DW-1:0]         shadow, active, active_nxt;
  logic                  shadow_empty, shadow_empty_nxt;
  scan_state_t           state, state_nxt;
  logic                  supp, supp_nxt;
  logic [BCD_W-1:0]      nib, bcd_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic                  lz_zero, err_nxt, accept, transfer;

  bcd_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx_nxt    (idx_nxt),
    .slot_start (slot_start),
    .show_start (show_start),
    .frame_last (frame_last)
  );

  // Handshake: load_data is captured on a rising edge where load_valid && load_ready;
  // load_ready is high exactly while the shadow buffer is empty, so valid is ignored otherwise.
  assign accept       = ld.load_valid && shadow_empty;
  assign transfer     = frame_done && !shadow_empty;
  assign ld.load_ready = shadow_empty;
  assign state_dbg    = state;

  always_comb begin
    active_nxt       = transfer ? shadow : active;
    shadow_empty_nxt = shadow_empty;
    if (transfer)    shadow_empty_nxt = 1'b1;
    else if (accept) shadow_empty_nxt = 1'b0;

    state_nxt = state;
    if (slot_start)      state_nxt = BLANK;
    else if (show_start) state_nxt = SHOW;

    nib     = active_nxt[idx_nxt*BCD_W +: BCD_W];
    lz_zero = 1'b1;
    err_nxt = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!bcd_valid(active_nxt[i*BCD_W +: BCD_W])) err_nxt = 1'b1;
      if (i >= int'(idx_nxt) && active_nxt[i*BCD_W +: BCD_W] != '0) lz_zero = 1'b0;
    end

    // Suppression is decided once per slot so a mid-slot lz_blank_en change waits for the next slot.
    supp_nxt = supp;
    if (slot_start)
      supp_nxt = !bcd_valid(nib) || (lz_blank_en && idx_nxt != '0 && lz_zero);

    sel_nxt = '0;
    if (state_nxt == SHOW && !supp_nxt) sel_nxt[idx_nxt] = 1'b1;
    bcd_nxt = bcd_valid(nib) ? nib : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BLANK;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      shadow_empty <= 1'b1;
      active       <= '0;
      supp         <= 1'b0;
      bcd_out      <= '0;
      digit_sel    <= '0;
      err_invalid  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      if (accept) shadow <= ld.load_data;
      shadow_empty <= shadow_empty_nxt;
      active       <= active_nxt;
      supp         <= supp_nxt;
      bcd_out      <= bcd_nxt;
      digit_sel    <= sel_nxt;
      err_invalid  <= err_nxt;
      frame_done   <= frame_last;
    end
  end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Bench for bcd_scan_mux: cycle-accurate scoreboard of the scanned output against queued loads.
module tb_bcd_scan_mux;
  import bcd_disp_pkg::*;

  localparam int ND    = 4;
  localparam int PS    = 16;
  localparam int BC    = 2;
  localparam int FRAME = ND * PS;
  localparam int W     = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lz_blank_en = 1'b0;
  logic [3:0]    bcd_out;
  logic [ND-1:0] digit_sel;
  logic          err_invalid, frame_done;
  scan_state_t   state_dbg;

  bcd_scan_mux_if #(.NUM_DIGITS(ND)) bif ();

  bcd_scan_mux #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld          (bif),
    .lz_blank_en (lz_blank_en),
    .bcd_out     (bcd_out),
    .digit_sel   (digit_sel),
    .err_invalid (err_invalid),
    .frame_done  (frame_done),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          tcyc = 0;
  logic [15:0] disp_val = '0;
  logic        busy = 1'b0;
  // exp_q: {frame index, value shown from that frame}; req_q: {first cycle to present, data}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] req_q[$];

  task automatic model_clear();
    tcyc = 0;
    disp_val = '0;
    busy = 1'b0;
    exp_q.delete();
    req_q.delete();
    bif.load_valid = 1'b0;
    bif.load_data = '0;
  endtask

  task automatic run_cycles(input int n, input string tag);
    logic [W-1:0] e;
    int fr, cyc, k, c;
    logic [3:0] nib;
    logic bad, lzs, err, acc, nb;
    logic [11:0] expv, obsv;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      fr = tcyc / FRAME; cyc = tcyc % FRAME; k = cyc / PS; c = cyc % PS;
      if (cyc == 0) begin
        while (exp_q.size() > 0) begin
          e = exp_q[0];
          if (int'(e[47:16]) != fr) break;
          disp_val = e[15:0];
          void'(exp_q.pop_front());
        end
      end
      nib = disp_val[k*4 +: 4];
      bad = (nib > 4'd9);
      lzs = lz_blank_en && (k != 0) && ((disp_val >> (k*4)) == 16'h0);
      err = 1'b0;
      for (int i = 0; i < ND; i++) if (disp_val[i*4 +: 4] > 4'd9) err = 1'b1;
      expv = {bad ? 4'h0 : nib, (c >= BC && !bad && !lzs) ? 4'(1 << k) : 4'h0,
              cyc == FRAME - 1, err, !busy, c >= BC};
      obsv = {bcd_out, digit_sel, frame_done, err_invalid, bif.load_ready, state_dbg == SHOW};
      checks++;
      if (obsv !== expv) begin
        failures++;
        $display("FAIL %s t=%0d frame=%0d cycle=%0d bcd/sel/fd/err/rdy/show got=%h expected=%h",
                 tag, tcyc, fr, cyc, obsv, expv);
      end
      acc = 1'b0;
      if (req_q.size() > 0) e = req_q[0];
      if (req_q.size() > 0 && int'(e[47:16]) <= tcyc) begin
        bif.load_valid = 1'b1;
        bif.load_data  = e[15:0];
        if (!busy) begin
          acc = 1'b1;
          void'(req_q.pop_front());
          exp_q.push_back({32'((cyc < FRAME - 1) ? fr + 1 : fr + 2), e[15:0]});
        end
      end else begin
        bif.load_valid = 1'b0;
        bif.load_data  = 16'($urandom);
      end
      nb = busy;
      if (cyc == FRAME - 1 && busy) nb = 1'b0;
      if (acc) nb = 1'b1;
      busy = nb;
      tcyc++;
    end
  endtask

  task automatic test_reset();
    logic [11:0] obsv;
    rst_n = 1'b0;
    lz_blank_en = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    obsv = {bcd_out, digit_sel, frame_done, err_invalid, bif.load_ready, state_dbg == SHOW};
    checks++;
    if (obsv !== 12'h002) begin
      failures++;
      $display("FAIL reset_values got=%h expected=%h", obsv, 12'h002);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_cycles(FRAME, "reset_frame");
  endtask

  task automatic test_load();
    lz_blank_en = 1'b0;
    req_q.push_back({32'(tcyc + 3), 16'h1234});
    run_cycles(3 * FRAME, "load_1234");
  endtask

  task automatic test_lz_blank();
    lz_blank_en = 1'b1;
    req_q.push_back({32'(tcyc + 10), 16'h0050});
    run_cycles(2 * FRAME, "lz_on_0050");
    lz_blank_en = 1'b0;
    run_cycles(FRAME, "lz_off_0050");
  endtask

  task automatic test_invalid();
    req_q.push_back({32'(tcyc + 4), 16'h12A4});
    run_cycles(2 * FRAME, "invalid_12a4");
    req_q.push_back({32'(tcyc + 4), 16'h1234});
    run_cycles(2 * FRAME, "reload_1234");
  endtask

  task automatic test_back_to_back();
    req_q.push_back({32'(tcyc + 5), 16'h5678});
    req_q.push_back({32'(tcyc + 10), 16'h9087});
    run_cycles(4 * FRAME, "back_to_back");
  endtask

  task automatic test_boundary_load();
    req_q.push_back({32'(tcyc + FRAME - 1), 16'h2468});
    run_cycles(3 * FRAME, "frame_done_load");
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < ND; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) v[15:8] = 8'h00;
      lz_blank_en = 1'($urandom_range(0, 1));
      req_q.push_back({32'(tcyc + $urandom_range(0, FRAME - 1)), v});
      run_cycles(2 * FRAME, "random");
    end
  endtask

  task automatic test_reset_mid_show();
    logic [11:0] obsv;
    lz_blank_en = 1'b0;
    req_q.push_back({32'(tcyc + 3), 16'h4321});
    req_q.push_back({32'(tcyc + FRAME + 5), 16'h8765});
    run_cycles(FRAME + 20, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    obsv = {bcd_out, digit_sel, frame_done, err_invalid, bif.load_ready, state_dbg == SHOW};
    checks++;
    if (obsv !== 12'h002) begin
      failures++;
      $display("FAIL async_reset got=%h expected=%h", obsv, 12'h002);
    end
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_cycles(3 * FRAME, "post_reset");
  endtask

  initial begin
    bif.load_valid = 1'b0;
    bif.load_data  = '0;
    test_reset();
    test_load();
    test_lz_blank();
    test_invalid();
    test_back_to_back();
    test_boundary_load();
    test_random();
    test_reset_mid_show();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
